// File: rtl/mem_arbiter_if.sv
// Bus-side handshake between mem_arbiter (master) and the unified SRAM/AXI-lite bridge (slave).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic [3:0]        bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory bus; data has priority, fetch has a starvation guard.
// Optional one-entry fetch buffer compiled in with `define MEM_ARB_IBUF_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  mem_arbiter_if.master     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INST = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_inst_ready;
  logic              r_data_ready;
  logic [31:0]       r_inst_rdata;
  logic [31:0]       r_data_rdata;
  logic              r_bus_req;
  logic [3:0]        r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;

  logic        w_inst_elig;
  logic        w_data_elig;
  logic        w_starved;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_ibuf_hit;
  logic [31:0] w_ibuf_word;
  logic        w_unused;

  // A requester still holding req during its own ready cycle must not be granted again.
  assign w_inst_elig  = inst_req & ~r_inst_ready;
  assign w_data_elig  = data_req & ~r_data_ready;
  assign w_starved    = (r_starve_cnt == C_LIMIT);
  assign w_grant_inst = (r_state == S_IDLE) & w_inst_elig & (w_starved | ~w_data_elig);
  assign w_grant_data = (r_state == S_IDLE) & w_data_elig & ~(w_starved & w_inst_elig);
  assign w_unused     = &{1'b0, inst_addr[1:0]};

`ifdef MEM_ARB_IBUF_EN
  logic              r_ibuf_valid;
  logic [ADDR_W-3:0] r_ibuf_addr;
  logic [31:0]       r_ibuf_word;

  assign w_ibuf_hit  = w_grant_inst & r_ibuf_valid & (r_ibuf_addr == inst_addr[ADDR_W-1:2]);
  assign w_ibuf_word = r_ibuf_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ibuf_valid <= 1'b0;
      r_ibuf_addr  <= '0;
      r_ibuf_word  <= '0;
    end else if ((r_state == S_INST) && bus.bus_ack) begin
      r_ibuf_valid <= 1'b1;
      r_ibuf_addr  <= r_bus_addr[ADDR_W-1:2];
      r_ibuf_word  <= bus.bus_rdata;
    end else if (w_grant_data && (data_wen != 4'b0000)) begin
      r_ibuf_valid <= 1'b0;
    end
  end
`else
  assign w_ibuf_hit  = 1'b0;
  assign w_ibuf_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
    end else begin
      // NOTE: non-blocking defaults first, so any branch that sets a ready yields a single-cycle pulse.
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ibuf_hit) begin
            r_inst_ready <= 1'b1;
            r_inst_rdata <= w_ibuf_word;
          end else if (w_grant_inst) begin
            r_state     <= S_INST;
            r_bus_req   <= 1'b1;
            r_bus_addr  <= {inst_addr[ADDR_W-1:2], 2'b00};
            r_bus_we    <= 4'b0000;
            r_bus_wdata <= '0;
          end else if (w_grant_data) begin
            r_state     <= S_DATA;
            r_bus_req   <= 1'b1;
            r_bus_addr  <= data_addr;
            r_bus_we    <= data_wen;
            r_bus_wdata <= data_wdata;
          end
        end
        S_INST, S_DATA: begin
          if (bus.bus_ack) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
            if (r_state == S_INST) begin
              r_inst_ready <= 1'b1;
              r_inst_rdata <= bus.bus_rdata;
            end else begin
              r_data_ready <= 1'b1;
              r_data_rdata <= bus.bus_rdata;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!inst_req || w_grant_inst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_data && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign inst_ready    = r_inst_ready;
  assign inst_rdata    = r_inst_rdata;
  assign data_ready    = r_data_ready;
  assign data_rdata    = r_data_rdata;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_rdata;
  logic          inst_ready;
  logic          data_req;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata;
  logic [31:0]   data_rdata;
  logic          data_ready;

  mem_arbiter_if #(.ADDR_W(AW)) bus_if ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus slave: random or forced wait states, optional stray acks while the bus is idle.
  int          wait_left   = -1;
  int          force_wait  = -1;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rdata = '0;
  bit          spurious_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wait_left         = -1;
      bus_if.bus_ack    = 1'b0;
      bus_if.bus_rdata  = '0;
    end else begin
      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_req) begin
        if (wait_left < 0) wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        if (wait_left == 0) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = force_rd_en ? force_rdata : $urandom;
          wait_left        = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left        = -1;
        bus_if.bus_ack   = spurious_en && ($urandom_range(0, 7) == 0);
        bus_if.bus_rdata = $urandom;
      end
    end
  end

  // Reference model: who owns the bus, what was granted, what comes back.
  typedef struct {
    int          owner;   // 0 none, 1 fetch, 2 data
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        irdy;
    logic        drdy;
    logic [31:0] irdata;
    logic [31:0] drdata;
    int          starve;
    logic        bv;
    logic [29:0] baddr;
    logic [31:0] bword;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.owner = 0; r.addr = '0; r.we = '0; r.wdata = '0;
    r.irdy = 1'b0; r.drdy = 1'b0; r.irdata = '0; r.drdata = '0;
    r.starve = 0; r.bv = 1'b0; r.baddr = '0; r.bword = '0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m);
    model_t n = m;
    int     pick = 0;
    bit     ie, de;
    n.irdy = 1'b0;
    n.drdy = 1'b0;
    if (m.owner == 0) begin
      ie = inst_req && !m.irdy;
      de = data_req && !m.drdy;
      if (ie && m.starve == LIMIT) pick = 1;
      else if (de)                 pick = 2;
      else if (ie)                 pick = 1;
      if (pick == 1 && IBUF && m.bv && m.baddr == inst_addr[31:2]) begin
        n.irdy   = 1'b1;
        n.irdata = m.bword;
      end else if (pick == 1) begin
        n.owner = 1; n.addr = {inst_addr[31:2], 2'b00}; n.we = 4'h0; n.wdata = '0;
      end else if (pick == 2) begin
        n.owner = 2; n.addr = data_addr; n.we = data_wen; n.wdata = data_wdata;
        if (data_wen != 4'h0) n.bv = 1'b0;
      end
      if (pick == 1)      n.starve = 0;
      else if (pick == 2) n.starve = (m.starve < LIMIT) ? m.starve + 1 : LIMIT;
    end else if (bus_if.bus_ack) begin
      if (m.owner == 1) begin
        n.irdy = 1'b1; n.irdata = bus_if.bus_rdata;
        n.bv = 1'b1; n.baddr = m.addr[31:2]; n.bword = bus_if.bus_rdata;
      end else begin
        n.drdy = 1'b1; n.drdata = bus_if.bus_rdata;
      end
      n.owner = 0;
    end
    if (!inst_req) n.starve = 0;
    return n;
  endfunction

  model_t m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("bus_req", bus_if.bus_req, m.owner != 0);
    if (m.owner != 0) begin
      check("bus_addr", bus_if.bus_addr, m.addr);
      check("bus_we", bus_if.bus_we, m.we);
      check("bus_wdata", bus_if.bus_wdata, m.wdata);
    end
    check("inst_ready", inst_ready, m.irdy);
    check("data_ready", data_ready, m.drdy);
    check("inst_rdata", inst_rdata, m.irdata);
    check("data_rdata", data_rdata, m.drdata);
  end

  function automatic logic [31:0] pick_iaddr();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0104;
      2:       return 32'h0000_0108 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  nd;
    bit  inst_seen;
    bit  prev_req;

    rst_n = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", bus_if.bus_req, 1'b0);
    check("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check("rst_inst_ready", inst_ready, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch, zero wait states.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0006;
    force_wait = 0; force_rd_en = 1'b1; force_rdata = 32'h2408_0001;
    @(negedge clk);
    check("f0_bus_req", bus_if.bus_req, 1'b1);
    check("f0_bus_addr", bus_if.bus_addr, 32'hBFC0_0004);
    check("f0_bus_we", bus_if.bus_we, 4'h0);
    check("f0_early_ready", inst_ready, 1'b0);
    @(negedge clk);
    check("f0_ready", inst_ready, 1'b1);
    check("f0_rdata", inst_rdata, 32'h2408_0001);
    check("f0_bus_drop", bus_if.bus_req, 1'b0);
    inst_req = 1'b0;
    @(negedge clk);
    check("f0_pulse_len", inst_ready, 1'b0);

    // Store, three wait states; data_req stays high through the ready cycle.
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0010; data_wdata = 32'h1234_ABCD;
    force_wait = 3; force_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_bus_req", bus_if.bus_req, 1'b1);
      check("st_bus_addr", bus_if.bus_addr, 32'h8000_0010);
      check("st_bus_we", bus_if.bus_we, 4'b0011);
      check("st_bus_wdata", bus_if.bus_wdata, 32'h1234_ABCD);
      check("st_early_ready", data_ready, 1'b0);
    end
    @(negedge clk);
    check("st_ready", data_ready, 1'b1);
    check("st_rdata", data_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    check("st_no_regrant", bus_if.bus_req, 1'b0);
    check("st_pulse_len", data_ready, 1'b0);
    data_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: data first, fetch straight after.
    inst_req = 1'b1; inst_addr = 32'h0000_2003;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_3000;
    force_wait = 0; force_rdata = 32'h1111_2222;
    @(negedge clk);
    check("sim_first_data", bus_if.bus_addr, 32'h0000_3000);
    @(negedge clk);
    check("sim_data_ready", data_ready, 1'b1);
    data_req = 1'b0;
    @(negedge clk);
    check("sim_then_inst_req", bus_if.bus_req, 1'b1);
    check("sim_then_inst_addr", bus_if.bus_addr, 32'h0000_2000);
    @(negedge clk);
    check("sim_inst_ready", inst_ready, 1'b1);
    inst_req = 1'b0;
    @(negedge clk);

    // Both held continuously: fetch is eligible in every data ready cycle, so it follows one data grant.
    force_wait = 1; force_rd_en = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0500;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0600;
    nd = 0; inst_seen = 1'b0; prev_req = 1'b0;
    for (int i = 0; i < 30 && inst_req; i++) begin
      @(negedge clk);
      if (bus_if.bus_req && !prev_req) begin
        if (bus_if.bus_addr == 32'h0000_0600 && !inst_seen) begin
          nd++;
          if (nd == 1) check("model_starve_pin", m.starve, 1);
        end else if (bus_if.bus_addr == 32'h0000_0500) begin
          inst_seen = 1'b1;
        end
      end
      prev_req = bus_if.bus_req;
      if (inst_ready) inst_req = 1'b0;
    end
    check("starve_inst_served", inst_seen, 1'b1);
    check("starve_data_before_inst", nd, 1);
    for (int i = 0; i < 20 && !data_ready; i++) @(negedge clk);
    check("starve_data_done", data_ready, 1'b1);
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-transaction.
    force_wait = 6;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h0000_0700; data_wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("mid_bus_req_before", bus_if.bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bus_req", bus_if.bus_req, 1'b0);
    check("mid_rst_bus_we", bus_if.bus_we, 4'h0);
    check("mid_rst_bus_addr", bus_if.bus_addr, 32'h0);
    check("mid_rst_data_ready", data_ready, 1'b0);
    check("mid_rst_inst_ready", inst_ready, 1'b0);
    check("mid_rst_data_rdata", data_rdata, 32'h0);
    data_req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", bus_if.bus_req, 1'b0);
    force_wait = 1; force_rd_en = 1'b1; force_rdata = 32'h55AA_55AA;
    inst_req = 1'b1; inst_addr = 32'h0000_0044;
    @(negedge clk);
    check("post_rst_bus_addr", bus_if.bus_addr, 32'h0000_0044);
    @(negedge clk);
    check("post_rst_wait", inst_ready, 1'b0);
    @(negedge clk);
    check("post_rst_ready", inst_ready, 1'b1);
    check("post_rst_rdata", inst_rdata, 32'h55AA_55AA);
    inst_req = 1'b0;
    @(negedge clk);

    // Repeated fetch of one word, then a store in between.
    force_wait = 0; force_rdata = 32'hABCD_0100;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    repeat (2) @(negedge clk);
    check("rf1_ready", inst_ready, 1'b1);
    inst_req = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; force_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    if (IBUF) begin
      check("rf2_hit_ready", inst_ready, 1'b1);
      check("rf2_hit_no_bus", bus_if.bus_req, 1'b0);
      check("rf2_hit_rdata", inst_rdata, 32'hABCD_0100);
    end else begin
      check("rf2_bus_req", bus_if.bus_req, 1'b1);
      @(negedge clk);
      check("rf2_ready", inst_ready, 1'b1);
    end
    inst_req = 1'b0;
    @(negedge clk);
    data_req = 1'b1; data_wen = 4'b0001; data_addr = 32'h0000_0900; data_wdata = 32'h0000_00AA;
    repeat (2) @(negedge clk);
    check("rf_store_ready", data_ready, 1'b1);
    data_req = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; force_rdata = 32'h1357_9BDF;
    @(negedge clk);
    check("rf3_goes_to_bus", bus_if.bus_req, 1'b1);
    @(negedge clk);
    check("rf3_rdata", inst_rdata, 32'h1357_9BDF);
    inst_req = 1'b0;
    @(negedge clk);

    // Randomized traffic; the model comparison runs every cycle.
    force_wait = -1; force_rd_en = 1'b0; spurious_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (inst_req) begin
        if (inst_ready) begin
          if ($urandom_range(0, 1) == 0) inst_addr = pick_iaddr();
          else                           inst_req  = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        inst_req = 1'b1; inst_addr = pick_iaddr();
      end
      if (data_req) begin
        if (data_ready) begin
          if ($urandom_range(0, 1) == 0) begin
            data_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            data_addr = $urandom; data_wdata = $urandom;
          end else begin
            data_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        data_req = 1'b1;
        data_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        data_addr = $urandom; data_wdata = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
